// File: rtl/mmul_pkg.sv
// Shared types and helpers for the systolic tile sequencer.
package mmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } mmul_state_t;

    // Cycles needed for the last injected beat to reach the far corner PE.
    function automatic int FLUSH_LEN(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/mmul_step_counter.sv
// Up-counter with synchronous clear and enable; last flags count == limit-1.
module mmul_step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W:0]   limit,
    output logic [W-1:0] count,
    output logic         last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    // limit is one bit wider so a limit of 2^W still fits.
    assign last = ({1'b0, count} == (limit - (W+1)'(1)));

endmodule

// File: rtl/mmul_tile_sequencer.sv
// Control FSM for one output-stationary NxN systolic tile.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// CLEAR | one cycle zeroing PE accumulators
// FEED  | admitting k_reg column beats from the source
// FLUSH | 2N-2 bubble steps to drain the skew pipeline
// DRAIN | presenting N accumulator rows to the sink
// DONE  | one-cycle completion pulse
module mmul_tile_sequencer
    import mmul_pkg::*;
#(
    parameter int N   = 4,
    parameter int K_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 acc_clear,
    output logic                 feed_en,
    output logic                 feed_bubble,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_row_sel
);

    localparam int ROW_W = $clog2(N);
    localparam int FL_W  = $clog2(2 * N - 1);
    localparam logic [FL_W:0]  FLUSH_LIMIT = (FL_W+1)'(FLUSH_LEN(N));
    localparam logic [ROW_W:0] ROW_LIMIT   = (ROW_W+1)'(N);

    mmul_state_t state, next_state;
    logic [K_W-1:0]   k_reg;
    logic [K_W-1:0]   beat_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic beat_en, beat_clr, beat_last;
    logic flush_en, flush_clr, flush_last;
    logic row_en, row_clr, row_last;
    logic unused_cnt;

    assign beat_en   = (state == FEED) && in_valid;
    assign beat_clr  = beat_en && beat_last;
    assign flush_en  = (state == FLUSH);
    assign flush_clr = flush_en && flush_last;
    assign row_en    = (state == DRAIN) && out_ready;
    assign row_clr   = row_en && row_last;

    assign unused_cnt = ^{beat_cnt, flush_cnt};

    mmul_step_counter #(.W(K_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (beat_clr),
        .en    (beat_en),
        .limit ({1'b0, k_reg}),
        .count (beat_cnt),
        .last  (beat_last)
    );

    mmul_step_counter #(.W(FL_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (flush_clr),
        .en    (flush_en),
        .limit (FLUSH_LIMIT),
        .count (flush_cnt),
        .last  (flush_last)
    );

    mmul_step_counter #(.W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (row_clr),
        .en    (row_en),
        .limit (ROW_LIMIT),
        .count (row_cnt),
        .last  (row_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k_reg <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                k_reg <= k_len;
            end
        end
    end

    always_comb begin
        next_state  = state;
        busy        = (state != IDLE);
        done        = 1'b0;
        in_ready    = 1'b0;
        acc_clear   = 1'b0;
        feed_en     = 1'b0;
        feed_bubble = 1'b0;
        out_valid   = 1'b0;
        out_row_sel = '0;
        case (state)
            IDLE: begin
                if (start) next_state = CLEAR;
            end
            CLEAR: begin
                acc_clear  = 1'b1;
                // A zero-depth tile skips straight to draining zeroed rows.
                next_state = (k_reg == '0) ? DRAIN : FEED;
            end
            FEED: begin
                in_ready = 1'b1;
                feed_en  = in_valid;
                if (beat_clr) next_state = FLUSH;
            end
            FLUSH: begin
                feed_en     = 1'b1;
                feed_bubble = 1'b1;
                if (flush_last) next_state = DRAIN;
            end
            DRAIN: begin
                out_valid   = 1'b1;
                out_row_sel = row_cnt;
                if (row_clr) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmul_tile_sequencer.sv
// Directed self-checking bench for the systolic tile sequencer.
module tb_mmul_tile_sequencer;

    localparam int N   = 4;
    localparam int K_W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [K_W-1:0] k_len = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           busy, done, in_ready, acc_clear, feed_en, feed_bubble, out_valid;
    logic [1:0]     out_row_sel;

    int checks = 0;
    int errors = 0;
    int ir_cnt, fe_cnt, fe_feed, ov_cnt, ov_first, done_cyc, done_cnt, done2_cyc;
    int clr_cnt, clr_last;
    int acc_rows[4];

    always #5 clk = ~clk;

    mmul_tile_sequencer #(.N(N), .K_W(K_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .acc_clear   (acc_clear),
        .feed_en     (feed_en),
        .feed_bubble (feed_bubble),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_sel (out_row_sel)
    );

    function automatic logic [8:0] obs_vec();
        return {busy, done, acc_clear, in_ready, feed_en, feed_bubble, out_valid, out_row_sel};
    endfunction

    // Expected outputs in cycle c of an unstalled tile of depth k.
    function automatic logic [8:0] exp_vec(input int c, input int k);
        logic b, d, ac, ir, fe, fb, ov;
        logic [1:0] rs;
        b  = (c >= 1) && (c <= k + 3*N);
        d  = (c == k + 3*N);
        ac = (c == 1);
        ir = (c >= 2) && (c <= k + 1);
        fe = (c >= 2) && (c <= k + 2*N - 1);
        fb = (c >= k + 2) && (c <= k + 2*N - 1);
        ov = (c >= k + 2*N) && (c <= k + 3*N - 1);
        rs = ov ? 2'(c - (k + 2*N)) : 2'd0;
        return {b, d, ac, ir, fe, fb, ov, rs};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        // reset behaviour
        #3 reset = 1'b0;
        #1 chk("reset_outputs", int'(obs_vec()), 0);
        tick();
        tick();
        chk("reset_outputs_held", int'(obs_vec()), 0);
        #3 reset = 1'b1;
        tick();

        // k=4 unstalled, k_len changed after start
        k_len = 16'd4; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0; k_len = 16'd9;
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("t1_cycle%0d", c), int'(obs_vec()), int'(exp_vec(c, 4)));
            tick();
        end

        // k=3 with in_valid low every other FEED cycle
        k_len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        ir_cnt = 0; fe_cnt = 0; fe_feed = 0; done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            in_valid = !(c == 3 || c == 5);
            #1;
            if (in_ready) begin
                ir_cnt++;
                if (feed_en) fe_feed++;
            end
            if (feed_en) fe_cnt++;
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
        in_valid = 1'b1;
        chk("t2_feed_beats", fe_feed, 3);
        chk("t2_feed_cycles", ir_cnt, 5);
        chk("t2_feed_en_total", fe_cnt, 3 + 2*N - 2);
        chk("t2_done_cycle", done_cyc, 17);

        // k=1 with out_ready low three cycles on row 2
        k_len = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 4; r++) acc_rows[r] = 0;
        done_cyc = -1;
        for (int c = 1; c <= 18; c++) begin
            out_ready = !(c >= 11 && c <= 13);
            #1;
            if (c >= 11 && c <= 13)
                chk($sformatf("t3_stall_cycle%0d", c), int'({out_valid, out_row_sel}), 6);
            if (out_valid && out_ready) acc_rows[out_row_sel]++;
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) chk($sformatf("t3_row%0d_accepts", r), acc_rows[r], 1);
        chk("t3_done_cycle", done_cyc, 16);

        // zero-depth tile
        k_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        ir_cnt = 0; fe_cnt = 0; ov_cnt = 0; ov_first = -1; done_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 1) chk("t4_clear", int'(acc_clear), 1);
            if (in_ready) ir_cnt++;
            if (feed_en) fe_cnt++;
            if (out_valid) begin
                ov_cnt++;
                if (ov_first < 0) ov_first = c;
            end
            if (done && done_cyc < 0) done_cyc = c;
            tick();
        end
        chk("t4_in_ready", ir_cnt, 0);
        chk("t4_feed_en", fe_cnt, 0);
        chk("t4_drain_cycles", ov_cnt, N);
        chk("t4_drain_first", ov_first, 2);
        chk("t4_done_cycle", done_cyc, 6);

        // reset asserted during FLUSH, released with start high
        k_len = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        chk("t5_in_flush", int'(feed_bubble), 1);
        reset = 1'b0;
        #1 chk("t5_reset_immediate", int'(obs_vec()), 0);
        done_cnt = 0;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done) done_cnt++;
            chk($sformatf("t5_reset_held%0d", i), int'(obs_vec()), 0);
        end
        #3 reset = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_no_done", done_cnt, 0);
        for (int c = 1; c <= 17; c++) begin
            chk($sformatf("t5_cycle%0d", c), int'(obs_vec()), int'(exp_vec(c, 4)));
            tick();
        end

        // start held across two tiles, then pulsed during FEED
        k_len = 16'd2; start = 1'b1;
        tick();
        clr_cnt = 0; clr_last = -1; done_cnt = 0; done_cyc = -1; done2_cyc = -1;
        for (int c = 1; c <= 35; c++) begin
            start = (c < 16) || (c == 17);
            #1;
            if (acc_clear) begin
                clr_cnt++;
                clr_last = c;
            end
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = c;
                else done2_cyc = c;
            end
            if (c == 30 || c == 35) chk($sformatf("t6_idle_cycle%0d", c), int'(busy), 0);
            tick();
        end
        start = 1'b0;
        chk("t6_clear_count", clr_cnt, 2);
        chk("t6_second_clear", clr_last, 16);
        chk("t6_done_count", done_cnt, 2);
        chk("t6_first_done", done_cyc, 14);
        chk("t6_second_done", done2_cyc, 29);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
